// File: rtl/serial_add_ctrl_pkg.sv
// Shared FSM encodings for the bit-serial add/subtract controller.
package serial_add_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder built from gates; purely combinational, zero latency, no flow control.
module FullAdderStructure (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  logic ab_x;
  logic ab_a;
  logic cp_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cp_a = ci & ab_x;
  assign s    = ab_x ^ ci;
  assign co   = ab_a | cp_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract over WIDTH cycles using one full adder; done pulses WIDTH+1 cycles after start.
// No backpressure: start is taken only in IDLE and ignored while busy, nothing is queued.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] srb;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  FullAdderStructure u_fa (sra[0], srb[0], carry, fa_co, fa_s);

  assign last_bit = (count == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sra    <= '0;
      srb    <= '0;
      carry  <= 1'b0;
      count  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sra   <= op_a;
            srb   <= sub ? ~op_b : op_b;
            carry <= sub;
            count <= '0;
          end
        end
        ST_RUN: begin
          result <= {fa_s, result[WIDTH-1:1]};
          sra    <= {1'b0, sra[WIDTH-1:1]};
          srb    <= {1'b0, srb[WIDTH-1:1]};
          carry  <= fa_co;
          count  <= count + CNT_W'(1);
          // On the MSB the carry flop holds the carry into the MSB.
          if (last_bit) begin
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; inj1/inj2 are sample indices at which an extra start pulse is fired.
  task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ec, input logic ev,
                       input int inj1, input int inj2, input string nm);
    int bcnt = 0;
    int dcnt = 0;
    int lat = 0;
    logic [7:0] r_at = 8'h00;
    logic c_at = 1'b0;
    logic v_at = 1'b0;
    start = 1'b1; sub = s; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        lat  = k;
        r_at = result;
        c_at = cout;
        v_at = ovf;
      end
      if (k == inj1 || k == inj2) begin
        start = 1'b1; sub = 1'b0; op_a = 8'hAA; op_b = 8'h55;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk({nm, " done_count"}, dcnt, 1);
    chk({nm, " latency"}, lat, 9);
    chk({nm, " busy_cycles"}, bcnt, 9);
    chk({nm, " result"}, {24'd0, r_at}, {24'd0, er});
    chk({nm, " cout"}, {31'd0, c_at}, {31'd0, ec});
    chk({nm, " ovf"}, {31'd0, v_at}, {31'd0, ev});
    chk({nm, " result_hold"}, {24'd0, result}, {24'd0, er});
    chk({nm, " flags_hold"}, {30'd0, cout, ovf}, {30'd0, ec, ev});
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h40, 8'h40, 8'h00, 1'b1, 1'b0};

    // Reset held with start asserted: nothing may begin.
    rst = 1'b1; start = 1'b1; sub = 1'b0; op_a = 8'h12; op_b = 8'h34;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", {24'd0, result}, 32'd0);
    chk("reset flags", {30'd0, cout, ovf}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post-reset idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].v,
            0, 0, $sformatf("vec%0d", i));
    end

    // Extra start pulses in RUN and in DONE are ignored.
    do_op(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 3, 9, "ignore_start");

    // Reset in the middle of an operation abandons it.
    begin
      int dseen = 0;
      start = 1'b1; sub = 1'b0; op_a = 8'h7F; op_b = 8'h7F;
      tick();
      start = 1'b0;
      for (int k = 1; k < 4; k++) begin
        if (done) dseen++;
        tick();
      end
      chk("midrst running", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      chk("midrst result", {24'd0, result}, 32'd0);
      chk("midrst flags", {30'd0, cout, ovf}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (done || busy) dseen++;
        tick();
      end
      chk("midrst no_done", dseen, 0);
    end
    do_op(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
